// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : fir_pkg
//  Purpose : Shared defaults and helpers for the FIR output capture block:
//            default sample width, tap count, FIFO depth, accumulator width
//            and the signed saturation limits for a given output width.
//  Rev     : 1.0  initial release
// ============================================================================
package fir_pkg;

    localparam int BIT_PREC = 8;
    localparam int TAPS     = 4;
    localparam int DEPTH    = 8;

    // Accumulator width of a TAPS-tap filter with BIT_PREC-bit samples/coeffs.
    function automatic int acc_width(input int bit_prec, input int taps);
        return 2 * bit_prec + taps - 1;
    endfunction

    localparam int ACC_W = acc_width(BIT_PREC, TAPS);

    // Largest representable signed value of a bit_prec-bit sample.
    function automatic longint sat_hi(input int bit_prec);
        return (longint'(1) <<< (bit_prec - 1)) - 1;
    endfunction

    // Smallest representable signed value of a bit_prec-bit sample.
    function automatic longint sat_lo(input int bit_prec);
        return -(longint'(1) <<< (bit_prec - 1));
    endfunction

endpackage : fir_pkg
`default_nettype wire

// File: rtl/fir_cap_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : fir_cap_fifo
//  Purpose : Synchronous FIFO with a combinational head read. Pointers carry
//            one extra wrap bit so full and empty are distinguished without
//            a separate counter. A push while full is accepted only when a
//            pop happens in the same cycle; otherwise it is ignored.
//  Ports   : clk, rst         - clock, synchronous active-high reset
//            push, push_data  - write request and data
//            pop              - remove head (ignored while empty)
//            pop_data         - current head entry (valid while !empty)
//            full, empty      - occupancy status
//  Rev     : 1.0  initial release
// ============================================================================
module fir_cap_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot the push needs.
    assign w_do_push = push & (~full | w_do_pop);

    assign pop_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule : fir_cap_fifo
`default_nettype wire

// File: rtl/fir_out_capture.sv
`default_nettype none
// ============================================================================
//  Module  : fir_out_capture
//  Purpose : Captures the FIR accumulator output, requantises it (round half
//            up, arithmetic shift right by SHIFT), saturates it to BIT_PREC
//            bits and queues it in an output FIFO with a valid/ready port.
//            A sample arriving while the FIFO is full with no pop is dropped
//            and the sticky ovf flag is raised.
//  Ports   : clk, rst          - clock, synchronous active-high reset
//            fir_en, out_wave  - accumulator output and its qualifier
//            m_valid, m_ready  - output handshake
//            m_data            - requantised sample at FIFO head
//            ovf               - sticky overflow (sample dropped)
//            sat_cnt, drop_cnt - saturation / drop statistics (optional)
//  Config  : define FIR_CAP_STATS_EN to add sat_cnt and drop_cnt.
//  Rev     : 1.0  initial release
// ============================================================================
module fir_out_capture #(
    parameter int BIT_PREC = fir_pkg::BIT_PREC,
    parameter int TAPS     = fir_pkg::TAPS,
    parameter int SHIFT    = BIT_PREC - 1,
    parameter int DEPTH    = fir_pkg::DEPTH
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          fir_en,
    input  logic [fir_pkg::acc_width(BIT_PREC, TAPS)-1:0] out_wave,
    output logic                                          m_valid,
    input  logic                                          m_ready,
    output logic [BIT_PREC-1:0]                           m_data,
    output logic                                          ovf
`ifdef FIR_CAP_STATS_EN
    ,
    output logic [15:0]                                   sat_cnt,
    output logic [15:0]                                   drop_cnt
`endif
);

    localparam int ACC_W = fir_pkg::acc_width(BIT_PREC, TAPS);
    localparam int XW    = ACC_W + 1;

    // Rounding constant is half an LSB of the result; zero when SHIFT is 0.
    localparam logic signed [XW-1:0] c_rnd    = XW'((longint'(1) <<< SHIFT) >>> 1);
    localparam logic signed [XW-1:0] c_sat_hi = XW'(fir_pkg::sat_hi(BIT_PREC));
    localparam logic signed [XW-1:0] c_sat_lo = XW'(fir_pkg::sat_lo(BIT_PREC));

    logic signed [XW-1:0]  w_ext;
    logic signed [XW-1:0]  w_sum;
    logic signed [XW-1:0]  w_shr;
    logic                  w_over_hi;
    logic                  w_under_lo;
    logic [BIT_PREC-1:0]   w_q;

    logic                  r_s1_valid;
    logic [BIT_PREC-1:0]   r_s1_data;
    logic                  r_ovf;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_drop;

    // ---------------------------------------------------------------------
    // Requantisation: one extra bit of headroom keeps the rounding add from
    // wrapping at the positive end of the accumulator range.
    // ---------------------------------------------------------------------
    assign w_ext      = {out_wave[ACC_W-1], out_wave};
    assign w_sum      = w_ext + c_rnd;
    assign w_shr      = w_sum >>> SHIFT;
    assign w_over_hi  = (w_shr > c_sat_hi);
    assign w_under_lo = (w_shr < c_sat_lo);

    always_comb begin
        w_q = w_shr[BIT_PREC-1:0];
        if (w_over_hi) begin
            w_q = c_sat_hi[BIT_PREC-1:0];
        end else if (w_under_lo) begin
            w_q = c_sat_lo[BIT_PREC-1:0];
        end
    end

    // ---------------------------------------------------------------------
    // Stage 1 register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= fir_en;
            if (fir_en) begin
                r_s1_data <= w_q;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stage 2: output FIFO
    // ---------------------------------------------------------------------
    assign m_valid = ~w_empty;
    assign w_pop   = m_valid & m_ready;
    assign w_drop  = r_s1_valid & w_full & ~w_pop;

    fir_cap_fifo #(
        .WIDTH (BIT_PREC),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (r_s1_valid),
        .push_data (r_s1_data),
        .pop       (w_pop),
        .pop_data  (m_data),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf = r_ovf;

`ifdef FIR_CAP_STATS_EN
    // ---------------------------------------------------------------------
    // Statistics: saturation is counted while the sample sits in stage 1.
    // ---------------------------------------------------------------------
    logic        r_s1_sat;
    logic [15:0] r_sat_cnt;
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_sat   <= 1'b0;
            r_sat_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_s1_sat <= fir_en & (w_over_hi | w_under_lo);
            if (r_s1_valid && r_s1_sat && (r_sat_cnt != 16'hFFFF)) begin
                r_sat_cnt <= r_sat_cnt + 16'd1;
            end
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign sat_cnt  = r_sat_cnt;
    assign drop_cnt = r_drop_cnt;
`endif

endmodule : fir_out_capture
`default_nettype wire

// File: doc/fir_out_capture.md
FIR_OUT_CAPTURE -- requirements
Module: fir_out_capture

Interface
REQ-001 Parameter BIT_PREC, default fir_pkg::BIT_PREC, input sample width and output sample width in bits.
REQ-002 Parameter TAPS, default fir_pkg::TAPS, filter tap count; ACC_W = 2*BIT_PREC+TAPS-1.
REQ-003 Parameter SHIFT, default BIT_PREC-1, right-shift applied to the accumulator (Q-format realignment), range 0..ACC_W-BIT_PREC.
REQ-004 Parameter DEPTH, default 8, output FIFO depth, power of two, >= 2.
REQ-005 Port clk, input, 1, the only clock; all logic rising-edge.
REQ-006 Port rst, input, 1, synchronous active-high reset.
REQ-007 Port fir_en, input, 1, filter output qualifier; out_wave is valid in every cycle fir_en=1.
REQ-008 Port out_wave, input, ACC_W, signed two's-complement FIR accumulator output.
REQ-009 Port m_valid, output, 1, FIFO head holds a sample.
REQ-010 Port m_ready, input, 1, consumer accepts the head when m_valid=1 and m_ready=1.
REQ-011 Port m_data, output, BIT_PREC, signed requantised sample at FIFO head.
REQ-012 Port ovf, output, 1, sticky flag: a sample was dropped because the FIFO was full.

Function
REQ-013 Stage 1 registers the value requant(out_wave) plus a valid bit in every cycle fir_en=1; when fir_en=0, the stage-1 valid bit is 0.
REQ-014 requant: add 2^(SHIFT-1) (omitted when SHIFT=0), arithmetic shift right by SHIFT, using ACC_W+1-bit intermediate arithmetic with no wrap.
REQ-015 Saturation clamps the result to [-2^(BIT_PREC-1), 2^(BIT_PREC-1)-1].
REQ-016 Stage 2 writes the stage-1 value into the FIFO when the stage-1 valid bit is 1; latency from fir_en sampled high to m_valid=1 is 2 cycles when the FIFO is empty.
REQ-017 m_data shall be driven directly from the FIFO head register or memory read with no added cycle; m_data is don't-care while m_valid=0.
REQ-018 A pop occurs on m_valid & m_ready; m_ready while empty has no effect.
REQ-019 When full, a push with a pop in the same cycle completes both and occupancy stays DEPTH.
REQ-020 When full, a push without a pop discards the sample, leaves FIFO contents unchanged and sets ovf.
REQ-021 Pointers wrap modulo DEPTH; occupancy is tracked with an extra pointer bit or a counter of width log2(DEPTH)+1.
REQ-022 Samples leave the FIFO in arrival order with no duplication.

Reset
REQ-023 When rst=1 at a clk edge: m_valid=0, ovf=0, FIFO empty, stage-1 valid=0, and all statistics counters are 0.
REQ-024 When rst is asserted mid-stream, all in-flight samples are discarded; the first fir_en after release gives m_valid at +2 cycles.

Configuration
REQ-025 Macro FIR_CAP_STATS_EN, when defined, adds output sat_cnt (16 bits), which increments on each stage-1 sample that saturated and holds at 16'hFFFF.
REQ-026 When FIR_CAP_STATS_EN is defined, output drop_cnt (16 bits) is also added; it increments on each discarded sample and holds at 16'hFFFF.
REQ-027 Without FIR_CAP_STATS_EN, neither port nor its logic exists and all other behaviour is identical.

Structure
REQ-028 ACC_W, a function computing the saturation limits, and the default DEPTH shall live in fir_pkg.
REQ-029 The FIFO shall be a sub-module fir_cap_fifo (parameters WIDTH, DEPTH; push/pop/full/empty).
REQ-030 Requantisation and saturation shall live in fir_out_capture.

Verification (BIT_PREC=8, TAPS=4, ACC_W=19, SHIFT=7, DEPTH=8)
REQ-031 Rounding case: out_wave=64 then 63, fir_en=1, m_ready=1 -> m_data 1 then 0; first m_valid 2 cycles after the first sample.
REQ-032 Saturation case: out_wave=20000, then -20000 -> m_data 127, then -128; with FIR_CAP_STATS_EN, sat_cnt=2.
REQ-033 Overflow case: 10 consecutive samples 128*k (k=1..10), m_ready=0 -> 8 entries held, ovf=1 (drop_cnt=2 when stats are enabled); releasing m_ready drains 1..8 in order.
REQ-034 Full with simultaneous push and pop: FIFO full, m_ready=1, fir_en=1 continuous -> no drop, ovf stays 0, occupancy stays 8.
REQ-035 Reset mid-stream: 4 samples queued, rst=1 for 1 cycle -> m_valid=0 and ovf=0 next cycle; the next sample appears 2 cycles after fir_en.
REQ-036 fir_en gaps: fir_en toggling 1,0,1,0 -> only 2 samples are queued.
